// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default oversample factor and
// parity-sense constants. Used by both the receiver and the transmitter.
package uart_pkg;

  // Receiver/transmitter frame states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Default number of baud-wave ticks per bit
  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  // Parity sense selectors
  localparam bit UART_PARITY_EVEN = 1'b0;
  localparam bit UART_PARITY_ODD  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_sync_edge.sv
// Multi-flop synchronizer with a rising-edge detector on the synchronized
// level. The reset value is a parameter so an idle-high line does not look
// like an edge or a start bit coming out of reset.
module uart_sync_edge #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Async,
  output logic o_Level,
  output logic o_Rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the asynchronous input through the synchronizer chain and keep the
  // previous synchronized value for edge detection.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_Async};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign o_Level = sync_q[STAGES-1];
  assign o_Rise  = sync_q[STAGES-1] & ~prev_q;

endmodule : uart_sync_edge

// File: rtl/uart_rx_oversample.sv
// UART receiver driven by the 16x oversample baud wave. Both the baud wave and
// the serial line are synchronized to i_Clk; each rising edge of the baud wave
// becomes a one-cycle tick and all frame decoding advances on ticks only.
// Frame: start, DATA_BITS data bits LSB first, optional parity, one stop bit.
// Build option: define UART_RX_PARITY_EN to add a parity bit after the data.
//
// Handshake: o_Rx_Valid is a one-cycle pulse with no back-pressure; o_Rx_Data
// changes only in the cycle o_Rx_Valid is high and holds until the next good
// frame. o_Frame_Err and o_Rx_Valid never pulse together; o_Parity_Err pulses
// alongside whichever of them ends the frame.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_ODD  = UART_PARITY_EVEN
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Baud,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Valid,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 tick;
  logic                 line;
  logic                 baud_level_unused;
  logic                 serial_rise_unused;

  // Current frame state; kept as a named signal so checkers can bind to it
  uart_state_t          state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  // Set once the line has been seen high; cleared by a framing error so a
  // break or stuck-low line cannot start a new frame.
  logic                 armed;

  uart_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_baud_sync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Async (i_Rx_Baud),
    .o_Level (baud_level_unused),
    .o_Rise  (tick)
  );

  uart_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_serial_sync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Async (i_Rx_Serial),
    .o_Level (line),
    .o_Rise  (serial_rise_unused)
  );

`ifdef UART_RX_PARITY_EN
  // Parity mismatch captured in the parity bit, reported with the stop bit
  logic par_bad;
`else
  logic parity_odd_unused;
  assign parity_odd_unused = PARITY_ODD;
  assign o_Parity_Err      = 1'b0;
`endif

  // Frame decoder: all moves on ticks, result pulses registered for one cycle
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      armed       <= 1'b0;
      o_Rx_Data   <= '0;
      o_Rx_Valid  <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      o_Parity_Err <= 1'b0;
`endif
    end else begin
      o_Rx_Valid  <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_Parity_Err <= 1'b0;
`endif
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (line) begin
              armed <= 1'b1;
            end else if (armed) begin
              state    <= ST_START;
              tick_cnt <= '0;
              o_Busy   <= 1'b1;
            end
          end
          ST_START: begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              if (!line) begin
                state   <= ST_DATA;
                bit_cnt <= '0;
              end else begin
                state  <= ST_IDLE;
                o_Busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_DATA: begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              shift_q  <= {line, shift_q[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + BW'(1);
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              par_bad  <= line ^ (^shift_q) ^ PARITY_ODD;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`endif
          ST_STOP: begin
            if (tick_cnt == FULL_M1) begin
              tick_cnt <= '0;
              state    <= ST_IDLE;
              o_Busy   <= 1'b0;
              if (line) begin
                o_Rx_Data  <= shift_q;
                o_Rx_Valid <= 1'b1;
              end else begin
                o_Frame_Err <= 1'b1;
                armed       <= 1'b0;
              end
`ifdef UART_RX_PARITY_EN
              o_Parity_Err <= par_bad;
`endif
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: begin
            state  <= ST_IDLE;
            o_Busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : uart_rx_oversample
